// File: rtl/kb_debounce_repeat.sv
// Multi-channel key debouncer: synchroniser, shared sample tick, per-channel
// stability filter and typematic auto-repeat with pressed/released/repeat pulses.
module kb_debounce_repeat #(
  parameter int               WIDTH        = 8,
  parameter int               TICK_DIV     = 250000,
  parameter int               STABLE_TICKS = 4,
  parameter int               REPEAT_DELAY = 100,
  parameter int               REPEAT_RATE  = 20,
  parameter logic [WIDTH-1:0] REPEAT_EN    = {WIDTH{1'b1}},
  parameter int               SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] repeat_p,
  output logic             any_active
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
  // One extra bit so the incremented count can equal the full period
  // even when it is a power of two.
  localparam logic [RW:0]   DELAY_END = (RW + 1)'(REPEAT_DELAY);
  localparam logic [RW:0]   RATE_END  = (RW + 1)'(REPEAT_RATE);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic [WIDTH-1:0] sync_stage [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [TW-1:0]    tick_cnt;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_stage[s] <= '0;
      end
    end else begin
      sync_stage[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_stage[s] <= sync_stage[s-1];
      end
    end
  end

  assign sync = sync_stage[SYNC_STAGES-1];
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [SW-1:0] stab_cnt;
      logic [RW-1:0] rep_cnt;
      logic [RW:0]   rep_inc;
      logic [1:0]    state;
      logic          level_q;
      logic          pressed_q;
      logic          released_q;
      logic          repeat_q;
      logic          differ;
      logic          accept;
      logic          accept_press;
      logic          accept_release;

      assign differ         = sync[gi] ^ level_q;
      assign accept         = tick & differ & (stab_cnt == STAB_LAST);
      assign accept_press   = accept & sync[gi];
      assign accept_release = accept & ~sync[gi];
      assign rep_inc        = {1'b0, rep_cnt} + (RW + 1)'(1);

      // Any tick that agrees with the current level restarts the count,
      // so only an unbroken run of disagreeing ticks flips the level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stab_cnt   <= '0;
          level_q    <= 1'b0;
          pressed_q  <= 1'b0;
          released_q <= 1'b0;
        end else begin
          pressed_q  <= 1'b0;
          released_q <= 1'b0;
          if (tick) begin
            if (!differ) begin
              stab_cnt <= '0;
            end else if (stab_cnt == STAB_LAST) begin
              stab_cnt   <= '0;
              level_q    <= sync[gi];
              pressed_q  <= sync[gi];
              released_q <= ~sync[gi];
            end else begin
              stab_cnt <= stab_cnt + SW'(1);
            end
          end
        end
      end

      // The release tick itself never advances the repeat counter.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state    <= IDLE;
          rep_cnt  <= '0;
          repeat_q <= 1'b0;
        end else begin
          repeat_q <= 1'b0;
          case (state)
            IDLE: begin
              if (accept_press && REPEAT_EN[gi]) begin
                state   <= DELAY;
                rep_cnt <= '0;
              end
            end
            DELAY: begin
              if (accept_release) begin
                state   <= IDLE;
                rep_cnt <= '0;
              end else if (tick) begin
                if (rep_inc == DELAY_END) begin
                  repeat_q <= 1'b1;
                  state    <= REPEAT;
                  rep_cnt  <= '0;
                end else begin
                  rep_cnt <= rep_inc[RW-1:0];
                end
              end
            end
            REPEAT: begin
              if (accept_release) begin
                state   <= IDLE;
                rep_cnt <= '0;
              end else if (tick) begin
                if (rep_inc == RATE_END) begin
                  repeat_q <= 1'b1;
                  rep_cnt  <= '0;
                end else begin
                  rep_cnt <= rep_inc[RW-1:0];
                end
              end
            end
            default: begin
              state   <= IDLE;
              rep_cnt <= '0;
            end
          endcase
        end
      end

      assign level[gi]    = level_q;
      assign pressed[gi]  = pressed_q;
      assign released[gi] = released_q;
      assign repeat_p[gi] = repeat_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_active <= 1'b0;
    end else begin
      any_active <= |level;
    end
  end

endmodule

// File: tb/tb_kb_debounce_repeat.sv
// Bench for kb_debounce_repeat: directed segment table with pulse counts,
// plus randomized key activity checked cycle-by-cycle against a reference model.
module tb_kb_debounce_repeat;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;
  localparam int SS = 2;
  localparam logic [W-1:0] EN = 4'b0111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] level, pressed, released, repeat_p;
  logic         any_active;

  kb_debounce_repeat #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .REPEAT_EN(EN), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw(raw), .level(level), .pressed(pressed),
    .released(released), .repeat_p(repeat_p), .any_active(any_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: raw delayed by SS edges, tick every TD-th edge since
  // reset, level flips after ST consecutive disagreeing ticks, repeat pulses
  // when ticks-held-since-press reaches RD, RD+RR, RD+2RR, ...
  logic [W-1:0] mq[$];
  int           n_edge;
  logic [W-1:0] m_lv;
  int           m_run [W];
  int           m_held [W];
  logic [W-1:0] e_lv, e_p, e_r, e_rep;
  logic         e_any;

  int           cnt_p [W];
  int           cnt_r [W];
  int           cnt_rep [W];
  logic [W-1:0] last_press;

  typedef struct {
    logic [W-1:0] raw;
    int           ncyc;
    logic [W-1:0] lvl;
    logic [15:0]  np;
    logic [15:0]  nr;
    logic [15:0]  nrep;
  } seg_t;

  seg_t segs [18];

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h expected=%h", nm, n_edge, got, exp);
    end
  endtask

  task automatic model_reset();
    mq = {};
    for (int i = 0; i < SS; i++) mq.push_back('0);
    n_edge = 0;
    m_lv = '0;
    for (int i = 0; i < W; i++) begin
      m_run[i] = 0;
      m_held[i] = -1;
    end
  endtask

  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] s;
    bit tk;
    s = mq.pop_front();
    mq.push_back(r);
    tk = ((n_edge % TD) == TD - 1);
    n_edge++;
    e_any = |m_lv;
    e_p = '0;
    e_r = '0;
    e_rep = '0;
    if (tk) begin
      for (int i = 0; i < W; i++) begin
        if (s[i] == m_lv[i]) m_run[i] = 0;
        else m_run[i]++;
        if (m_run[i] == ST) begin
          m_run[i] = 0;
          m_lv[i] = s[i];
          if (s[i]) begin
            e_p[i] = 1'b1;
            m_held[i] = EN[i] ? 0 : -1;
          end else begin
            e_r[i] = 1'b1;
            m_held[i] = -1;
          end
        end else if (m_lv[i] && m_held[i] >= 0) begin
          m_held[i]++;
          if (m_held[i] >= RD && ((m_held[i] - RD) % RR) == 0) e_rep[i] = 1'b1;
        end
      end
    end
    e_lv = m_lv;
  endtask

  task automatic step(input logic [W-1:0] r);
    raw = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check("level", 16'(level), 16'(e_lv));
    check("pressed", 16'(pressed), 16'(e_p));
    check("released", 16'(released), 16'(e_r));
    check("repeat_p", 16'(repeat_p), 16'(e_rep));
    check("any_active", 16'(any_active), 16'(e_any));
    for (int i = 0; i < W; i++) begin
      cnt_p[i] += int'(pressed[i]);
      cnt_r[i] += int'(released[i]);
      cnt_rep[i] += int'(repeat_p[i]);
    end
    if (pressed != '0) last_press = pressed;
  endtask

  // Called just after a rising edge: async assert, hold, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {level, pressed, released, repeat_p}, 16'h0);
    check("async_reset_any", 16'(any_active), 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] pack_cnt(input int c0, input int c1, input int c2, input int c3);
    pack_cnt = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
  endfunction

  initial begin
    logic [W-1:0] r;

    segs[0]  = '{4'hF, 16, 4'hF, 16'h1111, 16'h0000, 16'h0000};
    segs[1]  = '{4'h0, 16, 4'h0, 16'h0000, 16'h1111, 16'h0000};
    segs[2]  = '{4'h1, 12, 4'h1, 16'h0001, 16'h0000, 16'h0000};
    segs[3]  = '{4'h0, 16, 4'h0, 16'h0000, 16'h0001, 16'h0000};
    segs[4]  = '{4'h2,  8, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    segs[5]  = '{4'h0,  4, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    segs[6]  = '{4'h2,  8, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    segs[7]  = '{4'h0, 12, 4'h0, 16'h0000, 16'h0000, 16'h0000};
    segs[8]  = '{4'h4, 12, 4'h4, 16'h0100, 16'h0000, 16'h0000};
    segs[9]  = '{4'h4, 60, 4'h4, 16'h0000, 16'h0000, 16'h0600};
    segs[10] = '{4'h0, 16, 4'h0, 16'h0000, 16'h0100, 16'h0100};
    segs[11] = '{4'h8, 12, 4'h8, 16'h1000, 16'h0000, 16'h0000};
    segs[12] = '{4'h8, 80, 4'h8, 16'h0000, 16'h0000, 16'h0000};
    segs[13] = '{4'h0, 16, 4'h0, 16'h0000, 16'h1000, 16'h0000};
    segs[14] = '{4'h3, 12, 4'h3, 16'h0011, 16'h0000, 16'h0000};
    segs[15] = '{4'h3,  8, 4'h3, 16'h0000, 16'h0000, 16'h0000};
    segs[16] = '{4'h3, 12, 4'h3, 16'h0011, 16'h0000, 16'h0000};
    segs[17] = '{4'h0, 16, 4'h0, 16'h0000, 16'h0011, 16'h0000};

    model_reset();
    rst_n = 1'b0;
    raw = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", {level, pressed, released, repeat_p}, 16'h0);
    check("reset_any", 16'(any_active), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) begin
      if (k == 16) do_reset();
      for (int i = 0; i < W; i++) begin
        cnt_p[i] = 0;
        cnt_r[i] = 0;
        cnt_rep[i] = 0;
      end
      last_press = '0;
      for (int c = 0; c < segs[k].ncyc; c++) step(segs[k].raw);
      check("seg_level", 16'(level), 16'(segs[k].lvl));
      check("seg_pressed_cnt", pack_cnt(cnt_p[0], cnt_p[1], cnt_p[2], cnt_p[3]), segs[k].np);
      check("seg_released_cnt", pack_cnt(cnt_r[0], cnt_r[1], cnt_r[2], cnt_r[3]), segs[k].nr);
      check("seg_repeat_cnt", pack_cnt(cnt_rep[0], cnt_rep[1], cnt_rep[2], cnt_rep[3]), segs[k].nrep);
      if (k == 14 || k == 16) check("simul_press", 16'(last_press), 16'h0003);
      $display("seg %0d raw=%h cycles=%0d level=%h", k, segs[k].raw, segs[k].ncyc, level);
    end

    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 29) == 0) r[i] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
        $display("random reset at cycle %0d", c);
      end
      step(r);
    end
    $display("random phase done level=%h", level);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kb_debounce_repeat.md
Name: kb_debounce_repeat

Overview:
Parametrised multi-channel key debouncer for the keyboard/button front end. It feeds the game-control logic (move, rotate, drop).
- Each channel is synchronised, then sampled on a shared slow tick, and accepted only after N consecutive agreeing samples.
- Per channel it outputs a clean level plus one-cycle pressed, released and auto-repeat pulses.
- It replaces fixed-width, window-gated sampling with a true per-channel stability filter and typematic repeat.

Parameters:
WIDTH, 8, number of independent key channels
TICK_DIV, 250000, clk cycles per sample tick (200 Hz at 50 MHz); must be >= 2
STABLE_TICKS, 4, consecutive disagreeing ticks required before the level flips; must be >= 1
REPEAT_DELAY, 100, ticks from press to first repeat pulse; must be >= 1
REPEAT_RATE, 20, ticks between subsequent repeat pulses; must be >= 1
REPEAT_EN, {WIDTH{1'b1}}, per-channel mask; 0 disables auto-repeat on that channel
SYNC_STAGES, 2, flip-flops in input synchroniser; must be >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
raw  in  WIDTH  asynchronous key inputs, 1 = pressed
level  out  WIDTH  debounced key state
pressed  out  WIDTH  1-cycle pulse on accepted 0->1
released  out  WIDTH  1-cycle pulse on accepted 1->0
repeat_p  out  WIDTH  1-cycle auto-repeat pulse while held
any_active  out  1  OR-reduction of level, registered

Behaviour:
- Reset (rst_n low, async assert, sync deassert): clear synchroniser, tick counter, all stability/repeat counters, FSMs to IDLE, level, pressed, released, repeat_p and any_active. All outputs read 0 during reset and on the first cycle after it.
- Synchroniser: raw passes through SYNC_STAGES flops per bit. The last stage is sync[i].
- Tick generator: tick_cnt counts 0..TICK_DIV-1 and wraps. tick is high for exactly the one cycle when tick_cnt == TICK_DIV-1. The first tick after reset is at cycle TICK_DIV-1.
- Stability filter, per channel, evaluated only on tick cycles:
  - If sync[i] == level[i]: stab_cnt[i] <= 0.
  - If they differ and stab_cnt[i] < STABLE_TICKS-1: stab_cnt[i]++.
  - If they differ and stab_cnt[i] == STABLE_TICKS-1: level[i] <= sync[i], stab_cnt[i] <= 0, and pressed[i] or released[i] is asserted, all in the same clock edge. The pulse is therefore visible the cycle after the tick and lasts exactly 1 cycle.
  - Counter width is clog2(STABLE_TICKS) with a minimum of 1.
- Repeat FSM, per channel: states IDLE, DELAY, REPEAT. rep_cnt width is clog2(max(REPEAT_DELAY, REPEAT_RATE)).
  - IDLE: on an accepted press with REPEAT_EN[i]=1, go to DELAY with rep_cnt=0.
  - DELAY: on each tick rep_cnt++. When the incremented value equals REPEAT_DELAY, assert repeat_p[i] for 1 cycle, go to REPEAT with rep_cnt=0.
  - REPEAT: on each tick rep_cnt++. When the incremented value equals REPEAT_RATE, assert repeat_p[i] and set rep_cnt=0.
  - Accepted release from DELAY or REPEAT: go to IDLE immediately, same edge as released. No repeat_p may occur on or after that edge.
  - Ticks on which the release is accepted do not count toward repeat.
- Simultaneous events:
  - Channels are fully independent; any subset may pulse in the same cycle.
  - pressed and repeat_p never coincide on one channel, since the first repeat comes at least 1 tick after the press.
  - released and repeat_p never coincide on one channel.
- Glitches: any tick sample matching level resets stab_cnt, so a bounce shorter than STABLE_TICKS consecutive ticks never changes level.
- Latency (clean edge to pulse): SYNC_STAGES cycles, plus wait to the next tick, plus (STABLE_TICKS-1)*TICK_DIV cycles, plus 1.
- any_active: registered, so it lags level by 1 cycle.
- Reset mid-hold: all state clears. After rst_n releases with a key still held, a fresh pressed fires after STABLE_TICKS ticks.

Test Plan:
Params for all tests: WIDTH=4, TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, SYNC_STAGES=2.
- Reset: hold rst_n=0 with raw=4'hF -> every output is 0. Release -> level[3:0] rises together 3 ticks after sync settles, with pressed=4'hF for exactly 1 cycle.
- Clean press: raw[0] 0->1 and hold -> exactly one pressed[0] pulse after the 3rd consecutive tick seeing 1; level[0]=1 from that cycle; released and repeat_p stay 0 until ticks count out.
- Bounce reject: raw[1]=1 for 2 ticks, 0 for 1 tick, 1 for 2 ticks, then 0 -> level[1] stays 0 and no pulses on channel 1.
- Auto-repeat: hold raw[2] for 15 ticks after acceptance -> repeat_p[2] at ticks 5, 7, 9, 11, 13, 15 after pressed; release -> released[2] once, then no further repeat_p.
- Repeat mask: REPEAT_EN=4'b0111, hold raw[3] for 20 ticks -> pressed[3] once, no repeat_p[3].
- Simultaneous plus reset mid-hold: press raw[0] and raw[1] on the same cycle -> both pressed bits pulse on the same cycle. Assert rst_n during DELAY -> outputs clear asynchronously; after release, pressed re-fires for the still-held keys.
